// File: rtl/vga_trace_writer.sv
// Streams 16-bit sample magnitudes into a 640-column trace in VGA graphic memory,
// sharing the memory write port with the host. Optional macro: PEAK_DETECT_EN.
module vga_trace_writer #(
    parameter int unsigned BASE  = 4096,
    parameter int unsigned COLS  = 640,
    parameter int unsigned YMAX  = 479,
    parameter int unsigned SHIFT = 7
) (
    input  logic        mclk,
    input  logic        mrst,
    input  logic        hcs,
    input  logic        hwr,
    input  logic [12:0] haddr,
    input  logic [15:0] hdin,
    input  logic        start,
    input  logic [7:0]  dec,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic        mcs,
    output logic        mwr,
    output logic [12:0] maddr,
    output logic [15:0] min
);

    localparam int unsigned CW       = $clog2(COLS);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [15:0] YMAX_W   = 16'(YMAX);
    localparam logic [12:0] BASE_W   = 13'(BASE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_PEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Screen row for a magnitude: large samples land near the top (row 0).
    function automatic logic [15:0] row_map(input logic [15:0] smp);
        logic [15:0] sh;
        sh = smp >> SHIFT;
        if (sh > YMAX_W) begin
            sh = YMAX_W;
        end else begin
            sh = sh;
        end
        return YMAX_W - sh;
    endfunction

    state_t        state_q, state_d;
    logic [7:0]    dec_q, dec_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [15:0]   row_q, row_d;
    logic [15:0]   pick_s;
    logic          accept_s;
    logic          mcs_q, mcs_d, mwr_q, mwr_d;
    logic [12:0]   maddr_q, maddr_d;
    logic [15:0]   min_q, min_d;
    logic          s_ready_q, s_ready_d, busy_q, busy_d, done_q, done_d;
`ifdef PEAK_DETECT_EN
    logic [15:0]   acc_q, acc_d;
`endif

    // Sample that represents the column so far (running peak or plain last sample).
    always_comb begin
`ifdef PEAK_DETECT_EN
        if ((cnt_q == 8'd0) || (s_data > acc_q)) begin
            pick_s = s_data;
        end else begin
            pick_s = acc_q;
        end
`else
        pick_s = s_data;
`endif
    end

    // Sequencer next state plus registered bus and status requests.
    always_comb begin
        state_d  = state_q;
        dec_d    = dec_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
`ifdef PEAK_DETECT_EN
        acc_d    = acc_q;
`endif
        accept_s = (state_q == ST_ACCUM) && s_valid;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dec_d   = dec;
                    col_d   = '0;
                    cnt_d   = 8'd0;
`ifdef PEAK_DETECT_EN
                    acc_d   = 16'd0;
`endif
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && (cnt_q == dec_q)) begin
                    row_d   = row_map(pick_s);
                    cnt_d   = 8'd0;
`ifdef PEAK_DETECT_EN
                    acc_d   = 16'd0;
`endif
                    state_d = ST_PEND;
                end else if (accept_s) begin
                    cnt_d   = cnt_q + 8'd1;
`ifdef PEAK_DETECT_EN
                    acc_d   = pick_s;
`endif
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_PEND: begin
                // The host owns the port whenever it asks; the trace write just waits.
                if (!hcs && (col_q == LAST_COL)) begin
                    state_d = ST_DONE;
                end else if (!hcs) begin
                    col_d   = col_q + {{(CW-1){1'b0}}, 1'b1};
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (hcs) begin
            mcs_d   = 1'b1;
            mwr_d   = hwr;
            maddr_d = haddr;
            min_d   = hdin;
        end else if (state_q == ST_PEND) begin
            mcs_d   = 1'b1;
            mwr_d   = 1'b1;
            maddr_d = BASE_W + 13'(col_q);
            min_d   = row_q;
        end else begin
            mcs_d   = 1'b0;
            mwr_d   = 1'b0;
            maddr_d = 13'd0;
            min_d   = 16'd0;
        end

        s_ready_d = (state_d == ST_ACCUM);
        busy_d    = (state_d == ST_ACCUM) || (state_d == ST_PEND);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers; reset drops any pending trace write.
    always_ff @(posedge mclk) begin
        if (mrst) begin
            state_q   <= ST_IDLE;
            dec_q     <= 8'd0;
            col_q     <= '0;
            cnt_q     <= 8'd0;
            row_q     <= 16'd0;
`ifdef PEAK_DETECT_EN
            acc_q     <= 16'd0;
`endif
            mcs_q     <= 1'b0;
            mwr_q     <= 1'b0;
            maddr_q   <= 13'd0;
            min_q     <= 16'd0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
`ifdef PEAK_DETECT_EN
            acc_q     <= acc_d;
`endif
            mcs_q     <= mcs_d;
            mwr_q     <= mwr_d;
            maddr_q   <= maddr_d;
            min_q     <= min_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign mcs     = mcs_q;
    assign mwr     = mwr_q;
    assign maddr   = maddr_q;
    assign min     = min_q;

endmodule

// File: tb/tb_vga_trace_writer.sv
// Self-checking bench for vga_trace_writer; expectations come from a column-level
// reference model (PEAK_DETECT_EN selects peak vs. last-sample columns).
module tb_vga_trace_writer;

    logic        mclk = 1'b0;
    logic        mrst, hcs, hwr, start, s_valid;
    logic [12:0] haddr;
    logic [15:0] hdin, s_data;
    logic [7:0]  dec;
    logic        s_ready, busy, done, mcs, mwr;
    logic [12:0] maddr;
    logic [15:0] min;

    vga_trace_writer dut (
        .mclk(mclk), .mrst(mrst), .hcs(hcs), .hwr(hwr), .haddr(haddr), .hdin(hdin),
        .start(start), .dec(dec), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .busy(busy), .done(done), .mcs(mcs), .mwr(mwr), .maddr(maddr), .min(min)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [12:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t log_q[$];
    ent_t trace_q[$];
    ent_t host_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    // Bus cycle log and done-pulse counter.
    always @(negedge mclk) begin
        cyc = cyc + 1;
        if (mcs === 1'b1) log_q.push_back('{cyc, mwr, maddr, min});
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic int ref_row(input int v);
        int q;
        q = v / 128;
        if (q > 479) q = 479;
        return 479 - q;
    endfunction

    function automatic int ref_col(input int peak, input int last);
`ifdef PEAK_DETECT_EN
        return ref_row(peak);
`else
        return ref_row(last);
`endif
    endfunction

    function automatic void split_log();
        trace_q.delete();
        host_q.delete();
        foreach (log_q[i]) begin
            if (log_q[i].a >= 13'd4096) trace_q.push_back(log_q[i]);
            else host_q.push_back(log_q[i]);
        end
    endfunction

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset();
        mrst = 1'b1; hcs = 1'b0; hwr = 1'b0; start = 1'b0; s_valid = 1'b0;
        tick();
        tick();
        mrst = 1'b0;
        log_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_sweep(input int d);
        dec = 8'(d);
        start = 1'b1;
        tick();
        start = 1'b0;
        dec = 8'($urandom_range(0, 255));
    endtask

    // Returns 1 ns after the edge that accepted the sample.
    task automatic send(input int v);
        bit got;
        got = 1'b0;
        s_data = 16'(v);
        s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge mclk);
            if (s_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: sample %0d not accepted, s_ready=%b required 1", v, s_ready);
        end else begin
            @(posedge mclk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        mrst = 1'b1; hcs = 1'b0; hwr = 1'b0; start = 1'b0; s_valid = 1'b0;
        haddr = 13'd0; hdin = 16'd0; s_data = 16'd0; dec = 8'd0;
        tick();
        tick();
        @(negedge mclk);
        checks++; if (mcs !== 1'b0) begin errors++; $display("FAIL reset_mcs: got %b want 0", mcs); end
        checks++; if (mwr !== 1'b0) begin errors++; $display("FAIL reset_mwr: got %b want 0", mwr); end
        checks++; if (maddr !== 13'd0) begin errors++; $display("FAIL reset_maddr: got %0d want 0", maddr); end
        checks++; if (min !== 16'd0) begin errors++; $display("FAIL reset_min: got %0d want 0", min); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        mrst = 1'b0;
        tick();
    endtask

    task automatic test_mapping();
        int smp[3];
        smp = '{0, 25600, 65535};
        do_reset();
        start_sweep(0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL map_busy: got %b want 1", busy); end
        for (int i = 0; i < 3; i++) send(smp[i]);
        repeat (3) tick();
        split_log();
        checks++;
        if (trace_q.size() != 3 || host_q.size() != 0) begin
            errors++;
            $display("FAIL map_count: got %0d trace/%0d host cycles want 3/0", trace_q.size(), host_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (trace_q[i].a !== 13'(4096 + i) || trace_q[i].d !== 16'(ref_row(smp[i])) || trace_q[i].wr !== 1'b1) begin
                    errors++;
                    $display("FAIL map_write%0d: got (%0d,%0d,wr=%b) want (%0d,%0d,wr=1)",
                             i, trace_q[i].a, trace_q[i].d, trace_q[i].wr, 4096 + i, ref_row(smp[i]));
                end
            end
        end
    endtask

    task automatic test_host_collision();
        do_reset();
        start_sweep(0);
        send(12800);
        hcs = 1'b1; hwr = 1'b1; haddr = 13'd16; hdin = 16'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge mclk);
            checks++;
            if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready%0d: got %b want 0", i, s_ready); end
            @(posedge mclk);
        end
        #1;
        hcs = 1'b0; hwr = 1'b0;
        repeat (3) tick();
        checks++;
        if (log_q.size() != 4) begin
            errors++;
            $display("FAIL host_count: got %0d bus cycles want 4", log_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_q[i].wr !== 1'b1 || log_q[i].a !== 13'd16 || log_q[i].d !== 16'd5) begin
                    errors++;
                    $display("FAIL host_cycle%0d: got (wr=%b,%0d,%0d) want (wr=1,16,5)", i, log_q[i].wr, log_q[i].a, log_q[i].d);
                end
            end
            checks++;
            if (log_q[3].a !== 13'd4096 || log_q[3].d !== 16'(ref_row(12800)) || log_q[3].cyc != log_q[2].cyc + 1) begin
                errors++;
                $display("FAIL host_then_trace: got (%0d,%0d,cyc+%0d) want (4096,%0d,cyc+1)",
                         log_q[3].a, log_q[3].d, log_q[3].cyc - log_q[2].cyc, ref_row(12800));
            end
        end
    endtask

    task automatic test_decimation();
        int exp_d;
        do_reset();
        start_sweep(3);
        send(12800); send(38400); send(25600); send(0);
        exp_d = ref_col(38400, 0);
        repeat (3) tick();
        split_log();
        checks++;
        if (trace_q.size() != 1) begin
            errors++;
            $display("FAIL dec_count: got %0d writes want 1", trace_q.size());
        end else begin
            checks++;
            if (trace_q[0].a !== 13'd4096 || trace_q[0].d !== 16'(exp_d)) begin
                errors++;
                $display("FAIL dec_write: got (%0d,%0d) want (4096,%0d)", trace_q[0].a, trace_q[0].d, exp_d);
            end
        end
    endtask

    task automatic test_full_sweep();
        int exp_q[$];
        int v;
        do_reset();
        start_sweep(0);
        for (int i = 0; i < 640; i++) begin
            v = $urandom_range(0, 65535);
            exp_q.push_back(ref_row(v));
            if (i == 300) dec = 8'd7;
            start = (i == 300);
            send(v);
            start = 1'b0;
        end
        repeat (6) tick();
        split_log();
        checks++;
        if (trace_q.size() != 640) begin
            errors++;
            $display("FAIL sweep_count: got %0d writes want 640", trace_q.size());
        end else begin
            for (int i = 0; i < 640; i++) begin
                checks++;
                if (trace_q[i].a !== 13'(4096 + i) || trace_q[i].d !== 16'(exp_q[i])) begin
                    errors++;
                    $display("FAIL sweep_write%0d: got (%0d,%0d) want (%0d,%0d)",
                             i, trace_q[i].a, trace_q[i].d, 4096 + i, exp_q[i]);
                end
            end
            checks++;
            if (trace_q[639].a !== 13'd4735) begin errors++; $display("FAIL sweep_last_addr: got %0d want 4735", trace_q[639].a); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL sweep_done: got %0d done cycles want 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_busy: got %b want 0", busy); end
    endtask

    task automatic test_mrst_pend();
        int smp[11];
        do_reset();
        start_sweep(0);
        for (int i = 0; i < 11; i++) begin
            smp[i] = $urandom_range(0, 65535);
            send(smp[i]);
        end
        mrst = 1'b1;
        tick();
        mrst = 1'b0;
        @(negedge mclk);
        checks++; if (mcs !== 1'b0) begin errors++; $display("FAIL mrst_mcs: got %b want 0", mcs); end
        repeat (3) tick();
        split_log();
        checks++;
        if (trace_q.size() != 10) begin
            errors++;
            $display("FAIL mrst_count: got %0d writes want 10", trace_q.size());
        end else begin
            checks++;
            if (trace_q[9].a !== 13'd4105) begin errors++; $display("FAIL mrst_last: got %0d want 4105", trace_q[9].a); end
        end
        log_q.delete();
        start_sweep(0);
        send(smp[10]);
        repeat (3) tick();
        split_log();
        checks++;
        if (trace_q.size() != 1) begin
            errors++;
            $display("FAIL mrst_restart_count: got %0d writes want 1", trace_q.size());
        end else begin
            checks++;
            if (trace_q[0].a !== 13'd4096 || trace_q[0].d !== 16'(ref_row(smp[10]))) begin
                errors++;
                $display("FAIL mrst_restart: got (%0d,%0d) want (4096,%0d)", trace_q[0].a, trace_q[0].d, ref_row(smp[10]));
            end
        end
    endtask

    task automatic test_random();
        ent_t exp_h[$];
        int   exp_t[$];
        int   d, nc, v, pk, k;
        ent_t he;
        for (int r = 0; r < 4; r++) begin
            exp_h.delete();
            exp_t.delete();
            do_reset();
            d  = $urandom_range(0, 3);
            nc = $urandom_range(2, 6);
            start_sweep(d);
            for (int c = 0; c < nc; c++) begin
                pk = 0;
                v = 0;
                for (int s = 0; s <= d; s++) begin
                    v = $urandom_range(0, 65535);
                    if (v > pk) pk = v;
                    send(v);
                    if ($urandom_range(0, 2) == 0) begin
                        k = $urandom_range(1, 3);
                        he = '{0, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 4095)), 16'($urandom_range(0, 65535))};
                        hcs = 1'b1; hwr = he.wr; haddr = he.a; hdin = he.d;
                        for (int j = 0; j < k; j++) begin
                            exp_h.push_back(he);
                            tick();
                        end
                        hcs = 1'b0;
                    end
                end
                exp_t.push_back(ref_col(pk, v));
            end
            repeat (4) tick();
            split_log();
            checks++;
            if (trace_q.size() != exp_t.size() || host_q.size() != exp_h.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d trace/%0d host want %0d/%0d",
                         r, trace_q.size(), host_q.size(), exp_t.size(), exp_h.size());
            end else begin
                foreach (exp_t[i]) begin
                    checks++;
                    if (trace_q[i].a !== 13'(4096 + i) || trace_q[i].d !== 16'(exp_t[i]) || trace_q[i].wr !== 1'b1) begin
                        errors++;
                        $display("FAIL rand%0d_trace%0d: got (%0d,%0d) want (%0d,%0d)",
                                 r, i, trace_q[i].a, trace_q[i].d, 4096 + i, exp_t[i]);
                    end
                end
                foreach (exp_h[i]) begin
                    checks++;
                    if (host_q[i].a !== exp_h[i].a || host_q[i].d !== exp_h[i].d || host_q[i].wr !== exp_h[i].wr) begin
                        errors++;
                        $display("FAIL rand%0d_host%0d: got (wr=%b,%0d,%0d) want (wr=%b,%0d,%0d)", r, i,
                                 host_q[i].wr, host_q[i].a, host_q[i].d, exp_h[i].wr, exp_h[i].a, exp_h[i].d);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_host_collision();
        test_decimation();
        test_full_sweep();
        test_mrst_pend();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_trace_writer.md
Name: vga_trace_writer

Overview:
- Sequencer that turns a stream of unsigned 16-bit magnitude samples into one 640-column trace in the VGA graphic memory block (word addresses 4096..4735).
- Each word holds a screen row (0 = top, 479 = bottom) for one column.
- Owns the vga memory write port (mcs/maddr/min/mwr) and shares it with the host; host writes have absolute priority.
- Sits between the DSP sample source, the host bus and the vga module, all in the mclk domain.

Parameters:
- BASE, 4096, first graphic-memory word address (column 0).
- COLS, 640, columns per sweep.
- YMAX, 479, bottom screen row; largest value ever written.
- SHIFT, 7, right shift applied to a sample before the row mapping.

Ports:
- mclk  in  1  memory/system clock; all logic rises on mclk.
- mrst  in  1  synchronous, active-high reset.
- hcs  in  1  host chip select.
- hwr  in  1  host write strobe.
- haddr  in  13  host word address.
- hdin  in  16  host write data.
- start  in  1  begin a sweep (sampled only in IDLE).
- dec  in  8  samples per column minus 1; latched at start.
- s_data  in  16  sample magnitude.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse, sweep complete.
- mcs  out  1  to vga mcs.
- mwr  out  1  to vga mwr.
- maddr  out  13  to vga maddr.
- min  out  16  to vga min.

Behaviour:
- Reset (mrst=1 at a mclk edge), all outputs 0:
  - mcs, mwr, maddr, min, s_ready, busy, done all 0.
  - state IDLE, column counter 0, sample counter 0, accumulator 0.
- States IDLE, ACCUM, PEND, DONE.
  - IDLE: start=1 latches dec, clears counters, goes to ACCUM. busy=1 from the next cycle.
  - ACCUM: s_ready=1. Each accepted sample updates the accumulator and the sample counter. On the acceptance where sample counter == dec, compute the row, hold it, clear the sample counter and go to PEND.
  - PEND: s_ready=0. If hcs=0 this cycle, issue the trace write and go to ACCUM with column+1. If column == COLS-1, go to DONE instead. If hcs=1, stay in PEND.
  - DONE: done=1 for exactly one cycle, busy=0 from the same cycle, then IDLE.
- Row mapping: y = YMAX - min(sample >> SHIFT, YMAX), 16-bit result, always in 0..YMAX.
- Bus outputs are registered; every request appears on mcs/mwr/maddr/min one cycle after it is decided.
  - Host: if hcs=1 at edge n, then at n+1 mcs=1, mwr=hwr, maddr=haddr, min=hdin.
  - Trace: mcs=1, mwr=1, maddr=BASE+column, min=y for exactly one cycle.
  - Otherwise mcs=0, mwr=0, maddr=0, min=0.
- Host priority is absolute; continuous hcs stalls the sweep indefinitely. No sample is lost, because s_ready=0 in PEND.
- start while busy=1 is ignored.
- dec changes mid-sweep have no effect.
- s_data must stay stable while s_valid=1 and s_ready=0.
- mrst mid-sweep:
  - any pending write is discarded, no bus cycle is issued;
  - return to IDLE; the next sweep restarts at address BASE.

Optional Feature:
- Macro: PEAK_DETECT_EN.
- Defined: the accumulator keeps the maximum sample of the dec+1 samples in the column; the row is computed from that maximum.
- Undefined: no accumulator; the row is computed from the last (dec-th) sample of the column, i.e. plain decimation.

Test Plan:
- Reset: hold mrst 2 cycles -> all outputs 0, busy=0.
- Mapping, dec=0, feed 0, 25600, 65535 -> writes (4096,479), (4097,279), (4098,0), each a single mcs=mwr=1 cycle.
- Host collision: PEND with hcs=1, hwr=1, haddr=16, hdin=5 held 3 cycles:
  - required: three host cycles to address 16 / data 5;
  - then the trace write one cycle after hcs falls;
  - s_ready=0 throughout the stall.
- Decimation, dec=3, samples 12800, 38400, 25600, 0:
  - with PEAK_DETECT_EN: one write to 4096 with min=179;
  - without it: min=479.
- Full sweep, dec=0, 640 samples:
  - required: last write to 4735;
  - done pulses exactly once, 1 cycle;
  - busy falls;
  - start pulsed mid-sweep is ignored (no address reset).
- mrst asserted in PEND at column 10 -> no write issued; a new start plus one sample writes address 4096.
